// File: rtl/lab3_mem_test_mem_responder_if.sv
// Cache memory port: request and response val/rdy channels.
// The master is the cache side and the slave is the memory responder.
interface lab3_mem_test_mem_responder_if;
  logic        memreq_val;
  logic        memreq_rdy;
  logic [2:0]  memreq_type;
  logic [7:0]  memreq_opaque;
  logic [31:0] memreq_addr;
  logic [1:0]  memreq_len;
  logic [31:0] memreq_data;

  logic        memresp_val;
  logic        memresp_rdy;
  logic [2:0]  memresp_type;
  logic [7:0]  memresp_opaque;
  logic [1:0]  memresp_test;
  logic [1:0]  memresp_len;
  logic [31:0] memresp_data;

  modport master (
    output memreq_val, memreq_type, memreq_opaque, memreq_addr, memreq_len, memreq_data,
    output memresp_rdy,
    input  memreq_rdy,
    input  memresp_val, memresp_type, memresp_opaque, memresp_test, memresp_len, memresp_data
  );

  modport slave (
    input  memreq_val, memreq_type, memreq_opaque, memreq_addr, memreq_len, memreq_data,
    input  memresp_rdy,
    output memreq_rdy,
    output memresp_val, memresp_type, memresp_opaque, memresp_test, memresp_len, memresp_data
  );
endinterface

// File: rtl/lab3_mem_test_mem_responder.sv
// Word-addressed test memory: byte-granular read/write/init, fixed-latency
// in-order responses, credit-limited so the delay line never has to stall.
module lab3_mem_test_mem_responder #(
  parameter int NUM_WORDS = 256,
  parameter int LATENCY   = 2
) (
  input logic                          clk,
  input logic                          reset,
  lab3_mem_test_mem_responder_if.slave mem
);
  localparam int AW = $clog2(NUM_WORDS);
  localparam int CW = $clog2(LATENCY + 3);
  localparam int QD = LATENCY + 2;
  localparam int PW = $clog2(QD);

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opq;
    logic [1:0]  len;
    logic [31:0] data;
  } ent_t;

  logic [31:0]   mem_q [NUM_WORDS];
  ent_t          q_q [QD];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d, outstanding_q, outstanding_d;

  logic          accept, fire, is_wr, enq_vld, unused_addr;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [2:0]    nraw, rem, nbytes;
  logic [4:0]    sh;
  logic [31:0]   lmask, wmask, word, rdata, wword;
  ent_t          in_ent, enq_ent, head;

  assign mem.memreq_rdy = !reset && (outstanding_q < CW'(LATENCY + 2));
  assign accept = mem.memreq_val && mem.memreq_rdy;
  assign fire   = mem.memresp_val && mem.memresp_rdy;
  assign is_wr  = (mem.memreq_type == 3'd1) || (mem.memreq_type == 3'd2);

  // Byte lane math: n bytes starting at off, clipped at the word boundary.
  assign idx         = mem.memreq_addr[2 +: AW];
  assign unused_addr = ^(mem.memreq_addr >> (2 + AW));
  assign off    = mem.memreq_addr[1:0];
  assign nraw   = (mem.memreq_len == 2'd0) ? 3'd4 : {1'b0, mem.memreq_len};
  assign rem    = 3'd4 - {1'b0, off};
  assign nbytes = (nraw > rem) ? rem : nraw;
  assign sh     = {off, 3'b000};
  assign lmask  = 32'hFFFF_FFFF >> {3'd4 - nbytes, 3'b000};
  assign wmask  = lmask << sh;
  assign word   = mem_q[idx];
  assign rdata  = (word >> sh) & lmask;
  assign wword  = (word & ~wmask) | ((mem.memreq_data << sh) & wmask);

  always_ff @(posedge clk) begin
    if (accept && is_wr) mem_q[idx] <= wword;
  end

  always_comb begin
    in_ent.typ  = mem.memreq_type;
    in_ent.opq  = mem.memreq_opaque;
    in_ent.len  = mem.memreq_len;
    in_ent.data = is_wr ? 32'd0 : rdata;
  end

  // The queue register write is the last delay stage, so LATENCY-1 stages sit here.
  generate
    if (LATENCY > 1) begin : g_dly
      logic [LATENCY-2:0] vld_pipe_q;
      ent_t               pl_q [LATENCY-1];
      always_ff @(posedge clk) begin
        if (reset) vld_pipe_q <= '0;
        else begin
          vld_pipe_q[0] <= accept;
          for (int k = 1; k < LATENCY - 1; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
        end
      end
      always_ff @(posedge clk) begin
        pl_q[0] <= in_ent;
        for (int k = 1; k < LATENCY - 1; k++) pl_q[k] <= pl_q[k-1];
      end
      assign enq_vld = vld_pipe_q[LATENCY-2];
      assign enq_ent = pl_q[LATENCY-2];
    end else begin : g_nodly
      assign enq_vld = accept;
      assign enq_ent = in_ent;
    end
  endgenerate

  always_comb begin
    rd_d          = rd_q;
    wr_d          = wr_q;
    cnt_d         = cnt_q;
    outstanding_d = outstanding_q;
    if (enq_vld) wr_d = (wr_q == PW'(QD - 1)) ? '0 : wr_q + PW'(1);
    if (fire)    rd_d = (rd_q == PW'(QD - 1)) ? '0 : rd_q + PW'(1);
    case ({enq_vld, fire})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    case ({accept, fire})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q          <= '0;
      wr_q          <= '0;
      cnt_q         <= '0;
      outstanding_q <= '0;
    end else begin
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      cnt_q         <= cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_vld) q_q[wr_q] <= enq_ent;
  end

  assign head               = q_q[rd_q];
  assign mem.memresp_val    = (cnt_q != '0);
  assign mem.memresp_type   = mem.memresp_val ? head.typ  : 3'd0;
  assign mem.memresp_opaque = mem.memresp_val ? head.opq  : 8'd0;
  assign mem.memresp_len    = mem.memresp_val ? head.len  : 2'd0;
  assign mem.memresp_data   = mem.memresp_val ? head.data : 32'd0;
  assign mem.memresp_test   = 2'd0;
endmodule

// File: tb/tb_lab3_mem_test_mem_responder.sv
// Directed bench for the test memory responder (NUM_WORDS=256, LATENCY=2).
module tb_lab3_mem_test_mem_responder;
  logic clk, reset;
  int total = 0, bad = 0;

  lab3_mem_test_mem_responder_if m();

  lab3_mem_test_mem_responder #(.NUM_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .mem(m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                         input logic [1:0] l, input logic [31:0] d);
    m.memreq_type = t; m.memreq_opaque = o; m.memreq_addr = a;
    m.memreq_len = l; m.memreq_data = d;
  endtask

  // One request with the response side always ready; waits are bounded.
  task automatic xact(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                      input logic [1:0] l, input logic [31:0] d,
                      output logic [31:0] rd, output logic [2:0] rt, output logic [7:0] ro,
                      output logic [1:0] rl, output bit ok);
    ok = 0; rd = '0; rt = '0; ro = '0; rl = '0;
    m.memresp_rdy = 1'b1;
    for (int i = 0; i < 20 && !m.memreq_rdy; i++) tick();
    set_req(t, o, a, l, d);
    m.memreq_val = 1'b1;
    tick();
    m.memreq_val = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m.memresp_val) begin
        rd = m.memresp_data; rt = m.memresp_type; ro = m.memresp_opaque; rl = m.memresp_len;
        ok = 1;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    m.memreq_val = 1'b0; m.memresp_rdy = 1'b1;
    set_req(3'd0, 8'd0, 32'd0, 2'd0, 32'd0);
    reset = 1'b1;
    tick(); tick();
    total++; if (m.memreq_rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy got=%b exp=0", m.memreq_rdy); end
    total++; if (m.memresp_val !== 1'b0) begin bad++; $display("FAIL rst_val got=%b exp=0", m.memresp_val); end
    reset = 1'b0;
    tick();
    total++; if (m.memreq_rdy !== 1'b1) begin bad++; $display("FAIL post_rst_rdy got=%b exp=1", m.memreq_rdy); end
    total++;
    if ({m.memresp_val, m.memresp_type, m.memresp_opaque, m.memresp_len, m.memresp_data, m.memresp_test} !== '0) begin
      bad++; $display("FAIL post_rst_resp val=%b type=%0d opq=%0h data=%0h exp all 0",
                      m.memresp_val, m.memresp_type, m.memresp_opaque, m.memresp_data);
    end
  endtask

  task automatic test_back_to_back();
    m.memresp_rdy = 1'b1;
    set_req(3'd1, 8'h01, 32'h10, 2'd0, 32'hDEADBEEF);
    m.memreq_val = 1'b1;
    tick();                                            // write accepted, cycle N+1
    set_req(3'd0, 8'h02, 32'h10, 2'd0, 32'd0);
    total++; if (m.memresp_val !== 1'b0) begin bad++; $display("FAIL b2b_early got=%b exp=0", m.memresp_val); end
    tick();                                            // read accepted, cycle N+2
    m.memreq_val = 1'b0;
    total++;
    if (m.memresp_val !== 1'b1 || m.memresp_type !== 3'd1 || m.memresp_opaque !== 8'h01 ||
        m.memresp_data !== 32'd0 || m.memresp_len !== 2'd0 || m.memresp_test !== 2'd0) begin
      bad++; $display("FAIL b2b_wr_resp val=%b type=%0d opq=%0h data=%0h exp 1/1/01/0",
                      m.memresp_val, m.memresp_type, m.memresp_opaque, m.memresp_data);
    end
    tick();                                            // cycle N+3
    total++;
    if (m.memresp_val !== 1'b1 || m.memresp_type !== 3'd0 || m.memresp_opaque !== 8'h02 ||
        m.memresp_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL b2b_rd_resp val=%b type=%0d opq=%0h data=%0h exp 1/0/02/deadbeef",
                      m.memresp_val, m.memresp_type, m.memresp_opaque, m.memresp_data);
    end
    tick();
    total++; if (m.memresp_val !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", m.memresp_val); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic [2:0] rt; logic [7:0] ro; logic [1:0] rl; bit ok;
    xact(3'd2, 8'h10, 32'h20, 2'd0, 32'h11223344, rd, rt, ro, rl, ok);
    total++; if (!ok || rd !== 32'd0 || rt !== 3'd2 || ro !== 8'h10) begin
      bad++; $display("FAIL sub_init ok=%0d data=%0h type=%0d opq=%0h exp 0/2/10", ok, rd, rt, ro); end
    xact(3'd1, 8'h11, 32'h21, 2'd1, 32'h000000AA, rd, rt, ro, rl, ok);
    total++; if (!ok || rd !== 32'd0 || rl !== 2'd1) begin
      bad++; $display("FAIL sub_wrbyte ok=%0d data=%0h len=%0d exp 0/1", ok, rd, rl); end
    xact(3'd0, 8'h12, 32'h22, 2'd2, 32'd0, rd, rt, ro, rl, ok);
    total++; if (!ok || rd !== 32'h00001122) begin
      bad++; $display("FAIL sub_rdhalf ok=%0d got=%0h exp=00001122", ok, rd); end
    xact(3'd0, 8'h13, 32'h20, 2'd0, 32'd0, rd, rt, ro, rl, ok);
    total++; if (!ok || rd !== 32'h1122AA44) begin
      bad++; $display("FAIL sub_rdword ok=%0d got=%0h exp=1122aa44", ok, rd); end
    xact(3'd0, 8'h14, 32'h23, 2'd0, 32'd0, rd, rt, ro, rl, ok);
    total++; if (!ok || rd !== 32'h00000011) begin
      bad++; $display("FAIL sub_rdtrunc ok=%0d got=%0h exp=00000011", ok, rd); end
    xact(3'd0, 8'h15, 32'h21, 2'd3, 32'd0, rd, rt, ro, rl, ok);
    total++; if (!ok || rd !== 32'h001122AA || rl !== 2'd3) begin
      bad++; $display("FAIL sub_rd3 ok=%0d got=%0h len=%0d exp=001122aa/3", ok, rd, rl); end
    xact(3'd5, 8'h16, 32'h20, 2'd0, 32'hFFFFFFFF, rd, rt, ro, rl, ok);
    total++; if (!ok || rd !== 32'h1122AA44 || rt !== 3'd5 || ro !== 8'h16) begin
      bad++; $display("FAIL sub_noop ok=%0d data=%0h type=%0d opq=%0h exp 1122aa44/5/16", ok, rd, rt, ro); end
  endtask

  task automatic test_wrap_trunc();
    logic [31:0] rd; logic [2:0] rt; logic [7:0] ro; logic [1:0] rl; bit ok;
    xact(3'd1, 8'h20, 32'h400, 2'd0, 32'h5, rd, rt, ro, rl, ok);
    xact(3'd0, 8'h21, 32'h000, 2'd0, 32'd0, rd, rt, ro, rl, ok);
    total++; if (!ok || rd !== 32'h5) begin bad++; $display("FAIL wrap ok=%0d got=%0h exp=5", ok, rd); end
    xact(3'd2, 8'h22, 32'h30, 2'd0, 32'h44332211, rd, rt, ro, rl, ok);
    xact(3'd1, 8'h23, 32'h33, 2'd0, 32'hCAFEF00D, rd, rt, ro, rl, ok);
    xact(3'd0, 8'h24, 32'h30, 2'd0, 32'd0, rd, rt, ro, rl, ok);
    total++; if (!ok || rd !== 32'h0D332211) begin bad++; $display("FAIL trunc ok=%0d got=%0h exp=0d332211", ok, rd); end
  endtask

  task automatic test_backpressure();
    int acc = 0, got = 0, baddata = 0, badord = 0;
    logic [7:0] rx[$];
    bit a, f;
    m.memresp_rdy = 1'b0;
    set_req(3'd0, 8'd0, 32'h10, 2'd0, 32'd0);
    m.memreq_val = 1'b1;
    for (int c = 0; c < 8; c++) begin
      a = m.memreq_val && m.memreq_rdy;
      tick();
      if (a) begin acc++; m.memreq_opaque = 8'(acc); end
    end
    total++; if (acc != 4) begin bad++; $display("FAIL bp_accepts got=%0d exp=4", acc); end
    total++; if (m.memreq_rdy !== 1'b0) begin bad++; $display("FAIL bp_rdy got=%b exp=0", m.memreq_rdy); end
    total++; if (m.memresp_val !== 1'b1 || m.memresp_opaque !== 8'd0) begin
      bad++; $display("FAIL bp_hold val=%b opq=%0h exp 1/0", m.memresp_val, m.memresp_opaque); end
    m.memresp_rdy = 1'b1;
    for (int c = 0; c < 60 && got < 10; c++) begin
      a = m.memreq_val && m.memreq_rdy;
      f = m.memresp_val;
      if (f) begin
        rx.push_back(m.memresp_opaque);
        if (m.memresp_data !== 32'hDEADBEEF) baddata++;
      end
      tick();
      if (f) got++;
      if (a) begin
        acc++;
        if (acc == 10) m.memreq_val = 1'b0;
        else m.memreq_opaque = 8'(acc);
      end
    end
    m.memreq_val = 1'b0;
    for (int i = 0; i < rx.size(); i++) if (rx[i] !== 8'(i)) badord++;
    total++; if (got != 10 || acc != 10) begin bad++; $display("FAIL bp_count got=%0d acc=%0d exp 10/10", got, acc); end
    total++; if (badord != 0 || baddata != 0) begin
      bad++; $display("FAIL bp_order misordered=%0d baddata=%0d exp 0/0", badord, baddata); end
    tick(); tick();
    total++; if (m.memresp_val !== 1'b0 || m.memreq_rdy !== 1'b1) begin
      bad++; $display("FAIL bp_drain val=%b rdy=%b exp 0/1", m.memresp_val, m.memreq_rdy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [2:0] rt; logic [7:0] ro; logic [1:0] rl; bit ok;
    xact(3'd1, 8'h30, 32'h44, 2'd0, 32'h12345678, rd, rt, ro, rl, ok);
    m.memresp_rdy = 1'b0;
    m.memreq_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(3'd0, 8'(8'h31 + i), 32'h44, 2'd0, 32'd0);
      tick();
    end
    m.memreq_val = 1'b0;
    tick(); tick();
    total++; if (m.memresp_val !== 1'b1) begin bad++; $display("FAIL mid_pending got=%b exp=1", m.memresp_val); end
    reset = 1'b1;
    tick();
    total++; if (m.memresp_val !== 1'b0 || m.memreq_rdy !== 1'b0) begin
      bad++; $display("FAIL mid_rst val=%b rdy=%b exp 0/0", m.memresp_val, m.memreq_rdy); end
    reset = 1'b0;
    m.memresp_rdy = 1'b1;
    tick();
    total++; if (m.memresp_val !== 1'b0 || m.memreq_rdy !== 1'b1) begin
      bad++; $display("FAIL mid_post val=%b rdy=%b exp 0/1", m.memresp_val, m.memreq_rdy); end
    xact(3'd0, 8'h3F, 32'h44, 2'd0, 32'd0, rd, rt, ro, rl, ok);
    total++; if (!ok || rd !== 32'h12345678 || ro !== 8'h3F) begin
      bad++; $display("FAIL mid_keep ok=%0d data=%0h opq=%0h exp 12345678/3f", ok, rd, ro); end
  endtask

  initial begin
    reset = 1'b1;
    m.memreq_val = 1'b0;
    m.memresp_rdy = 1'b1;
    set_req(3'd0, 8'd0, 32'd0, 2'd0, 32'd0);
    test_reset();
    test_back_to_back();
    test_subword();
    test_wrap_trunc();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
